// File: rtl/atmega_eep_prog.sv
// ATmega-style EEPROM controller: EEAR/EEDR/EECR register file, EEMPE arming
// window, timed erase/write programming FSM and an external load/dump port.
module atmega_eep_prog #(
  parameter string       PLATFORM          = "XILINX",
  parameter int unsigned BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned EEARH_ADDR        = 'h20,
  parameter int unsigned EEARL_ADDR        = 'h21,
  parameter int unsigned EEDR_ADDR         = 'h22,
  parameter int unsigned EECR_ADDR         = 'h23,
  parameter int unsigned EEP_SIZE          = 1024,
  parameter int unsigned PROG_CYCLES       = 16,
  parameter int unsigned EEMPE_WINDOW      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         int_o,
  input  logic                         ext_eep_en,
  input  logic [15:0]                  ext_eep_addr,
  input  logic [7:0]                   ext_eep_data_in,
  input  logic                         ext_eep_wr,
  input  logic                         ext_eep_rd,
  output logic [7:0]                   ext_eep_data_out,
  output logic                         ext_eep_busy,
  output logic                         content_modifyed,
  output logic [4:0]                   debug
);

  localparam int unsigned AW      = $clog2(EEP_SIZE);
  localparam int unsigned DUR_MAX = 2 * PROG_CYCLES;
  localparam int unsigned PCW     = $clog2(DUR_MAX + 1);
  localparam int unsigned WW      = $clog2(EEMPE_WINDOW + 1);
  localparam bit          XILINX_TGT = (PLATFORM == "XILINX");

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PROG   = 3'd2,
    S_COMMIT = 3'd3
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] prog_cnt_q, prog_cnt_d;
  logic [WW-1:0]  win_cnt_q, win_cnt_d;
  logic [AW-1:0]  eear_q, eear_d;
  logic [7:0]     eedr_q, eedr_d;
  logic           eerie_q, eerie_d;
  logic [1:0]     eepm_q, eepm_d;
  logic           eepe_q, eepe_d;
  logic           rd_pend_q, rd_pend_d;
  logic           ext_vld_q, ext_vld_d;
  logic           cm_q, cm_d;
  logic [1:0]     mode_q, mode_d;
  logic [AW-1:0]  pa_q, pa_d;
  logic [7:0]     pd_q, pd_d;

  // Array powers up erased; it is deliberately outside the reset domain.
  logic [7:0]     mem [EEP_SIZE] = '{default: 8'hFF};
  logic [7:0]     mem_rd_q;
  logic           mem_we, mem_re;
  logic [AW-1:0]  mem_wa, mem_ra;
  logic [7:0]     mem_wd, prog_result;

  logic           idle, eempe, wr_h, wr_l, wr_d, wr_c;
  logic           ext_wr_act, ext_rd_act, ext_act, arm, start, eere_req;
  logic [15:0]    eear16_q, eear16_n;
  logic           unused_ok;

  assign idle       = (state_q == S_IDLE);
  assign eempe      = (win_cnt_q != '0);
  assign wr_h       = wr & (addr == BUS_ADDR_DATA_LEN'(EEARH_ADDR));
  assign wr_l       = wr & (addr == BUS_ADDR_DATA_LEN'(EEARL_ADDR));
  assign wr_d       = wr & (addr == BUS_ADDR_DATA_LEN'(EEDR_ADDR));
  assign wr_c       = wr & (addr == BUS_ADDR_DATA_LEN'(EECR_ADDR));
  assign ext_wr_act = ext_eep_en & ext_eep_wr & idle;
  assign ext_rd_act = ext_eep_en & ext_eep_rd & idle;
  assign ext_act    = ext_wr_act | ext_rd_act;
  assign arm        = wr_c & bus_in[2] & ~bus_in[1];
  // Side port has priority over a CPU read/programming start in the same cycle.
  assign start      = wr_c & bus_in[1] & eempe & idle & ~ext_act & (bus_in[5:4] != 2'b11);
  assign eere_req   = wr_c & bus_in[0] & idle & ~ext_act & ~start;
  assign eear16_q   = 16'(eear_q);
  assign unused_ok  = ^{ext_eep_addr, XILINX_TGT};

  assign int_o            = eerie_q & idle;
  assign ext_eep_busy     = ~idle;
  assign content_modifyed = cm_q;
  assign debug            = {eempe, state_q, eepe_q};
  assign ext_eep_data_out = (ext_eep_rd & ext_eep_en & ext_vld_q) ? mem_rd_q : 8'h00;

  // State and control register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prog_cnt_q <= '0;
      win_cnt_q  <= '0;
      eear_q     <= '0;
      eedr_q     <= 8'h00;
      eerie_q    <= 1'b0;
      eepm_q     <= 2'b00;
      eepe_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      ext_vld_q  <= 1'b0;
      cm_q       <= 1'b0;
      mode_q     <= 2'b00;
      pa_q       <= '0;
      pd_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      prog_cnt_q <= prog_cnt_d;
      win_cnt_q  <= win_cnt_d;
      eear_q     <= eear_d;
      eedr_q     <= eedr_d;
      eerie_q    <= eerie_d;
      eepm_q     <= eepm_d;
      eepe_q     <= eepe_d;
      rd_pend_q  <= rd_pend_d;
      ext_vld_q  <= ext_vld_d;
      cm_q       <= cm_d;
      mode_q     <= mode_d;
      pa_q       <= pa_d;
      pd_q       <= pd_d;
    end
  end

  // Programming FSM next state and phase counter.
  always_comb begin
    state_d    = state_q;
    prog_cnt_d = prog_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d    = S_PROG;
        // FETCH and COMMIT take one cycle each, so PROG runs for D-1 cycles.
        prog_cnt_d = (mode_q == 2'b00) ? PCW'(DUR_MAX - 1) : PCW'(PROG_CYCLES - 1);
      end
      S_PROG: begin
        if (prog_cnt_q <= PCW'(1)) state_d = S_COMMIT;
        else prog_cnt_d = prog_cnt_q - PCW'(1);
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: array port control, commit value and modify pulse.
  always_comb begin
    case (mode_q)
      2'b01:   prog_result = 8'hFF;
      2'b10:   prog_result = mem_rd_q & pd_q;
      default: prog_result = pd_q;
    endcase
    mem_we = ext_wr_act | (state_q == S_COMMIT);
    mem_wa = (state_q == S_COMMIT) ? pa_q : ext_eep_addr[AW-1:0];
    mem_wd = (state_q == S_COMMIT) ? prog_result : ext_eep_data_in;
    mem_re = ext_rd_act | eere_req | (state_q == S_FETCH);
    if (state_q == S_FETCH) mem_ra = pa_q;
    else if (ext_rd_act)    mem_ra = ext_eep_addr[AW-1:0];
    else                    mem_ra = eear_q;
    cm_d      = mem_we;
    ext_vld_d = ext_rd_act;
  end

  // CPU-visible register updates.
  always_comb begin
    eear16_n  = eear16_q;
    eedr_d    = eedr_q;
    eerie_d   = eerie_q;
    eepm_d    = eepm_q;
    eepe_d    = eepe_q;
    win_cnt_d = win_cnt_q;
    mode_d    = mode_q;
    pa_d      = pa_q;
    pd_d      = pd_q;
    rd_pend_d = eere_req;

    if (idle && wr_h) eear16_n[15:8] = bus_in;
    if (idle && wr_l) eear16_n[7:0]  = bus_in;
    eear_d = eear16_n[AW-1:0];

    if (idle && wr_d) eedr_d = bus_in;
    if (rd_pend_q)    eedr_d = mem_rd_q;

    if (wr_c) eerie_d = bus_in[3];
    if (wr_c && idle) eepm_d = bus_in[5:4];

    if (win_cnt_q != '0) win_cnt_d = win_cnt_q - WW'(1);
    if (arm)             win_cnt_d = WW'(EEMPE_WINDOW);

    if (start) begin
      eepe_d    = 1'b1;
      win_cnt_d = '0;
      mode_d    = bus_in[5:4];
      pa_d      = eear_q;
      pd_d      = eedr_q;
    end
    if (state_q == S_COMMIT) eepe_d = 1'b0;
  end

  // Byte array with one write port and one registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (mem_re) mem_rd_q <= mem[mem_ra];
  end

  // I/O read mux.
  always_comb begin
    bus_out = 8'h00;
    if (rd) begin
      if (addr == BUS_ADDR_DATA_LEN'(EEARH_ADDR))      bus_out = eear16_q[15:8];
      else if (addr == BUS_ADDR_DATA_LEN'(EEARL_ADDR)) bus_out = eear16_q[7:0];
      else if (addr == BUS_ADDR_DATA_LEN'(EEDR_ADDR))  bus_out = eedr_q;
      else if (addr == BUS_ADDR_DATA_LEN'(EECR_ADDR))
        bus_out = {2'b00, eepm_q, eerie_q, eempe, eepe_q, 1'b0};
    end
  end

endmodule

// File: tb/tb_atmega_eep_prog.sv
// Scoreboard bench for atmega_eep_prog: stimulus queues expected values,
// a negedge monitor pops and compares whenever a sample point is presented.
module tb_atmega_eep_prog;

  localparam logic [7:0] A_EEARH = 8'h20;
  localparam logic [7:0] A_EEARL = 8'h21;
  localparam logic [7:0] A_EEDR  = 8'h22;
  localparam logic [7:0] A_EECR  = 8'h23;
  localparam int K_BUS = 0;
  localparam int K_PRB = 1;
  localparam int K_EXT = 2;
  localparam int K_CM  = 3;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      tag;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        wr, rd;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        int_o;
  logic        ext_eep_en;
  logic [15:0] ext_eep_addr;
  logic [7:0]  ext_eep_data_in;
  logic        ext_eep_wr, ext_eep_rd;
  logic [7:0]  ext_eep_data_out;
  logic        ext_eep_busy;
  logic        content_modifyed;
  logic [4:0]  debug;

  logic        probe, ext_cap, cm_req;
  item_t       sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cm_cnt = 0;

  atmega_eep_prog #(
    .PLATFORM("XILINX"), .BUS_ADDR_DATA_LEN(8),
    .EEARH_ADDR('h20), .EEARL_ADDR('h21), .EEDR_ADDR('h22), .EECR_ADDR('h23),
    .EEP_SIZE(512), .PROG_CYCLES(4), .EEMPE_WINDOW(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
    .bus_in(bus_in), .bus_out(bus_out), .int_o(int_o),
    .ext_eep_en(ext_eep_en), .ext_eep_addr(ext_eep_addr),
    .ext_eep_data_in(ext_eep_data_in), .ext_eep_wr(ext_eep_wr),
    .ext_eep_rd(ext_eep_rd), .ext_eep_data_out(ext_eep_data_out),
    .ext_eep_busy(ext_eep_busy), .content_modifyed(content_modifyed),
    .debug(debug)
  );

  always #5 clk = ~clk;

  task automatic push(input int k, input logic [7:0] e, input string t);
    item_t it;
    it.kind = k; it.exp = e; it.tag = t;
    sb.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] a, input logic [7:0] e, input string t);
    push(K_BUS, e, t);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // Expected probe byte: {debug[4:0], int, busy, content_modifyed}
  task automatic probe_chk(input logic [7:0] e, input string t);
    push(K_PRB, e, t);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic cm_chk(input logic [7:0] e, input string t);
    push(K_CM, e, t);
    cm_req = 1'b1;
    tick();
    cm_req = 1'b0;
  endtask

  task automatic ext_wr(input logic [15:0] a, input logic [7:0] d);
    ext_eep_addr = a; ext_eep_data_in = d; ext_eep_en = 1'b1; ext_eep_wr = 1'b1;
    tick();
    ext_eep_wr = 1'b0; ext_eep_en = 1'b0;
  endtask

  task automatic ext_rd(input logic [15:0] a, input logic [7:0] e, input string t);
    ext_eep_addr = a; ext_eep_en = 1'b1; ext_eep_rd = 1'b1;
    tick();
    push(K_EXT, e, t);
    ext_cap = 1'b1;
    tick();
    ext_cap = 1'b0; ext_eep_rd = 1'b0; ext_eep_en = 1'b0;
  endtask

  // Monitor: compare on every presented sample point, then count commit pulses.
  always @(negedge clk) begin
    item_t      it;
    logic [7:0] act;
    if (rd || probe || ext_cap || cm_req) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_sample: no expected entry queued at %0t", $time);
      end else begin
        it = sb.pop_front();
        case (it.kind)
          K_BUS:   act = bus_out;
          K_PRB:   act = {debug, int_o, ext_eep_busy, content_modifyed};
          K_EXT:   act = ext_eep_data_out;
          default: act = 8'(cm_cnt);
        endcase
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h at %0t", it.tag, act, it.exp, $time);
        end
      end
    end
    if (content_modifyed) cm_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = 8'h00; wr = 1'b0; rd = 1'b0; bus_in = 8'h00;
    ext_eep_en = 1'b0; ext_eep_addr = 16'h0; ext_eep_data_in = 8'h00;
    ext_eep_wr = 1'b0; ext_eep_rd = 1'b0;
    probe = 1'b0; ext_cap = 1'b0; cm_req = 1'b0;
    wait_n(3);
    probe_chk(8'h00, "reset_probe");
    rst = 1'b1;
    tick();
    probe_chk(8'h00, "post_reset_probe");
    io_rd(A_EECR,  8'h00, "reset_eecr");
    io_rd(A_EEDR,  8'h00, "reset_eedr");
    io_rd(A_EEARH, 8'h00, "reset_earh");

    // Erase+write A5 into address 5
    io_wr(A_EEARH, 8'h00);
    io_wr(A_EEARL, 8'h05);
    io_wr(A_EEDR,  8'hA5);
    io_wr(A_EECR,  8'h04);
    io_wr(A_EECR,  8'h02);
    probe_chk(8'h1A, "ew_fetch");
    io_rd(A_EECR, 8'h02, "ew_eepe_set");
    wait_n(6);
    probe_chk(8'h3A, "ew_commit");
    probe_chk(8'h01, "ew_idle");
    io_rd(A_EECR, 8'h00, "ew_eepe_clr");
    io_wr(A_EEDR, 8'h00);
    io_wr(A_EECR, 8'h01);
    io_rd(A_EECR, 8'h00, "eere_selfclr");
    io_rd(A_EEDR, 8'hA5, "ew_readback");
    cm_chk(8'd1, "cm_after_ew");

    // Write-only: A5 & 3C
    io_wr(A_EEDR, 8'h3C);
    io_wr(A_EECR, 8'h24);
    io_wr(A_EECR, 8'h22);
    probe_chk(8'h1A, "wo_fetch");
    wait_n(3);
    probe_chk(8'h3A, "wo_commit");
    probe_chk(8'h01, "wo_idle");
    io_wr(A_EECR, 8'h01);
    io_rd(A_EECR, 8'h00, "wo_eecr");
    io_rd(A_EEDR, 8'h24, "wo_readback");

    // Erase-only
    io_wr(A_EECR, 8'h14);
    io_wr(A_EECR, 8'h12);
    wait_n(5);
    probe_chk(8'h01, "eo_idle");
    io_rd(A_EECR, 8'h10, "eo_eepm");
    io_wr(A_EECR, 8'h11);
    io_rd(A_EECR, 8'h10, "eo_eecr");
    io_rd(A_EEDR, 8'hFF, "eo_readback");

    // EEMPE window expiry
    io_wr(A_EEDR, 8'h11);
    io_wr(A_EECR, 8'h04);
    io_rd(A_EECR, 8'h04, "win_first");
    wait_n(2);
    io_rd(A_EECR, 8'h04, "win_last");
    io_rd(A_EECR, 8'h00, "win_expired");
    io_wr(A_EECR, 8'h02);
    io_rd(A_EECR, 8'h00, "late_start_eepe");
    probe_chk(8'h00, "late_start_idle");
    io_wr(A_EECR, 8'h01);
    io_rd(A_EECR, 8'h00, "late_eecr");
    io_rd(A_EEDR, 8'hFF, "late_unchanged");

    // Reserved mode
    io_wr(A_EECR, 8'h34);
    io_wr(A_EECR, 8'h32);
    io_rd(A_EECR, 8'h34, "pm11_eecr");
    probe_chk(8'h80, "pm11_idle");
    wait_n(4);

    // EERIE interrupt and busy write-blocking
    io_wr(A_EEDR, 8'h5A);
    io_wr(A_EECR, 8'h0C);
    io_wr(A_EECR, 8'h0A);
    probe_chk(8'h1A, "irq_busy");
    io_wr(A_EEDR, 8'h00);
    io_rd(A_EEDR, 8'h5A, "busy_eedr_kept");
    io_wr(A_EEARL, 8'h07);
    io_rd(A_EEARL, 8'h05, "busy_eear_kept");
    io_wr(A_EECR, 8'h09);
    io_rd(A_EECR, 8'h0A, "busy_eecr");
    wait_n(1);
    probe_chk(8'h3A, "irq_commit");
    probe_chk(8'h05, "irq_assert");
    probe_chk(8'h04, "irq_level");
    io_wr(A_EECR, 8'h00);
    cm_chk(8'd4, "cm_after_irq");
    ext_rd(16'h0005, 8'h5A, "ext_rd_5a");

    // Address truncation and side port
    io_wr(A_EEARH, 8'hFF);
    io_rd(A_EEARH, 8'h01, "earh_trunc");
    io_wr(A_EEARL, 8'hFF);
    io_rd(A_EEARL, 8'hFF, "earl_ff");
    ext_wr(16'h01FF, 8'h77);
    ext_rd(16'h01FF, 8'h77, "ext_rd_1ff");
    ext_rd(16'hFFFF, 8'h77, "ext_rd_alias");
    io_wr(A_EECR, 8'h01);
    io_rd(A_EECR, 8'h00, "eere2_eecr");
    io_rd(A_EEDR, 8'h77, "eere_1ff");

    // Side port beats a same-cycle CPU start
    io_wr(A_EECR, 8'h04);
    addr = A_EECR; bus_in = 8'h02; wr = 1'b1;
    ext_eep_addr = 16'h0000; ext_eep_en = 1'b1; ext_eep_rd = 1'b1;
    tick();
    wr = 1'b0; ext_eep_en = 1'b0; ext_eep_rd = 1'b0;
    io_rd(A_EECR, 8'h04, "side_wins_eecr");
    probe_chk(8'h80, "side_wins_idle");
    wait_n(3);

    // Side-port write ignored while busy
    io_wr(A_EEARH, 8'h00);
    io_wr(A_EEARL, 8'h05);
    io_wr(A_EECR, 8'h14);
    io_wr(A_EECR, 8'h12);
    ext_wr(16'h0010, 8'h33);
    wait_n(4);
    probe_chk(8'h01, "busy_ext_idle");
    ext_rd(16'h0010, 8'hFF, "ext_wr_ignored");
    ext_rd(16'h0005, 8'hFF, "eo_via_ext");
    cm_chk(8'd6, "cm_after_ext");

    // Reset in the middle of PROG
    io_wr(A_EEDR, 8'h42);
    io_wr(A_EECR, 8'h0C);
    io_wr(A_EECR, 8'h0A);
    wait_n(4);
    rst = 1'b0;
    probe_chk(8'h00, "rst_mid_prog");
    rst = 1'b1;
    probe_chk(8'h00, "rst_release");
    io_rd(A_EECR, 8'h00, "rst_eecr");
    io_rd(A_EEDR, 8'h00, "rst_eedr");
    io_rd(A_EEARL, 8'h00, "rst_earl");
    io_wr(A_EEARL, 8'h05);
    io_wr(A_EECR, 8'h01);
    io_rd(A_EECR, 8'h00, "rst_eere_eecr");
    io_rd(A_EEDR, 8'hFF, "rst_byte_kept");
    ext_rd(16'h0005, 8'hFF, "rst_ext_kept");
    cm_chk(8'd6, "cm_final");

    wait_n(2);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/atmega_eep_prog.md
# atmega_eep_prog

Parametrised ATmega-compatible EEPROM controller with real programming timing: atomic erase+write, erase-only and write-only modes, a self-clearing EEMPE arming window, a busy period during which EEPE reads back as 1, and a level EE_READY interrupt. It sits on the 8-bit I/O bus beside the other io-atmega peripherals. It also exposes a side port for external loading or dumping of the array, for example by a debugger or a flash-image loader.

## Interface
- PLATFORM, "XILINX", target family, passed through for RAM inference
- BUS_ADDR_DATA_LEN, 8, I/O address width
- EEARH_ADDR / EEARL_ADDR / EEDR_ADDR / EECR_ADDR, 'h20 / 'h21 / 'h22 / 'h23, register addresses
- EEP_SIZE, 1024, array depth in bytes; power of two, 2..65536; AW = $clog2(EEP_SIZE)
- PROG_CYCLES, 16, clocks for one erase or one write phase; must be ≥ 2
- EEMPE_WINDOW, 4, clocks EEMPE stays armed after being set; must be ≥ 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  BUS_ADDR_DATA_LEN  I/O address
- wr / rd  in  1  I/O write / read strobe
- bus_in  in  8  I/O write data
- bus_out  out  8  I/O read data, combinational, 0 unless rd hits a register
- int  out  1  EE_READY interrupt, level
- ext_eep_en  in  1  side-port select
- ext_eep_addr  in  16  side-port address; bits ≥ AW ignored
- ext_eep_data_in  in  8  side-port write data
- ext_eep_wr / ext_eep_rd  in  1  side-port write / read strobe
- ext_eep_data_out  out  8  side-port read data, 0 unless ext_eep_rd & ext_eep_en
- ext_eep_busy  out  1  FSM not IDLE; side-port strobes are ignored while 1
- content_modifyed  out  1  one-cycle pulse on every array commit
- debug  out  5  {eempe_armed, state[2:0], EEPE}

## Operation
- Registers
  - EEAR = {EEARH, EEARL}. Only the low AW bits are stored; unimplemented bits read 0.
  - EEDR is a single register. CPU writes and read results both land in it.
  - EECR bits: 0 EERE, 1 EEPE, 2 EEMPE, 3 EERIE, 5:4 EEPM. Bits 7:6 read 0.
- Array initialises to 8'hFF (erased). Array content is not affected by reset.
- EEMPE arming
  - Writing EECR with bus_in[2]=1 and bus_in[1]=0 sets EEMPE and loads the window counter with EEMPE_WINDOW.
  - EEMPE auto-clears when the counter reaches 0.
- Programming start
  - Writing EECR with bus_in[1]=1 while EEMPE is set starts programming. EEPE is set, EEMPE is cleared, and EEPM and EEAR/EEDR are latched.
  - A write with EEPE=1 while EEMPE is clear is ignored for bit 1. The other bits are written normally.
- Programming modes (EEPM)
  - 00: erase+write, duration 2*PROG_CYCLES, result = EEDR.
  - 01: erase-only, duration PROG_CYCLES, result = 8'hFF.
  - 10: write-only, duration PROG_CYCLES, result = old & EEDR.
  - 11: reserved. Nothing is started and EEPE stays 0.
- FSM states: IDLE, FETCH (1 cycle, captures the old byte; used by every mode), PROG (counter runs), COMMIT (array write, EEPE←0, content_modifyed pulse) → IDLE.
- While not IDLE:
  - CPU writes to EEARH, EEARL, EEDR and EEPM are ignored.
  - EERE writes are ignored and read back 0.
  - EERIE remains writable.
- Read: writing EERE=1 while IDLE reads array[EEAR] into EEDR. EERE self-clears.
- int = EERIE & (state==IDLE). It is a level signal with no acknowledge.
- Side port, IDLE only
  - ext_eep_wr commits ext_eep_data_in immediately, with no programming delay, and pulses content_modifyed.
  - ext_eep_rd returns array data with one-cycle latency.
  - If the side port and a CPU EERE/EEPE start occur in the same cycle, the side port wins and the CPU action is dropped.

## Timing
- Reset values
  - All registers are 0, state IDLE, EEMPE window 0.
  - Outputs: int=0, content_modifyed=0, ext_eep_busy=0, ext_eep_data_out=0, debug=0.
- EEMPE: with the set on cycle T, EEMPE reads 1 through cycle T+EEMPE_WINDOW and reads 0 from T+EEMPE_WINDOW+1.
- EEPE start on cycle T:
  - ext_eep_busy=1 from T+1.
  - FETCH at T+1.
  - COMMIT on the edge ending cycle T+1+D, where D is the mode duration.
  - EEPE reads 0, int asserts (if EERIE=1) and ext_eep_busy=0 from cycle T+2+D.
- EERE on cycle T: EEDR holds the new value from cycle T+2. EERE reads 0 from T+1.
- Reset asserted mid-programming aborts the operation with no array write. All registers go to reset values.

## Test plan
- EEAR=5, EEDR=8'hA5, EEPM=00, EECR←04 then EECR←02 next cycle → EEPE=1 for 2*PROG_CYCLES+1 cycles, then array[5]=A5. One content_modifyed pulse. EERE readback gives A5.
- array[5]=A5, EEPM=10, EEDR=3C, armed program → array[5]=24 after PROG_CYCLES+1 cycles. Then EEPM=01 → array[5]=FF.
- EECR←04, wait EEMPE_WINDOW+1 cycles, EECR←02 → EEPE stays 0 and array is unchanged. EEPM=11 with a valid arm → no start.
- EERIE=1 during programming → int=0 while busy and int=1 the cycle EEPE clears. A write of EEDR=00 during busy → EEDR still holds its old value.
- With EEP_SIZE=512, EEARH←FF → reads back 01. The ext port writes addr 'h1FF=77 while idle; ext_eep_rd returns 77 one cycle later. An ext write during busy is ignored.
- rst low at mid-PROG → EEPE=0, int=0, busy=0, and the target byte keeps its pre-operation value.
